seven_seg_display_controller: RTL and testbench
===============================================

Name: seven_seg_display_controller

Overview:
Shared multi-digit seven-segment display controller. Two requesters (e.g. game score and timer) submit binary values over a req/gnt handshake. A round-robin arbiter picks one requester. A sequential double-dabble FSM converts the value to BCD, one bit per cycle. The block then registers the active-low segment patterns for NUM_DIGITS digits, with optional leading-zero blanking and overflow indication.

Parameters:
IN_WIDTH, 8, width of binary input values and number of conversion shift cycles
NUM_DIGITS, 3, number of decimal digits converted and driven
BLANK_LEADING, 1, 1 = blank leading zero digits; 0 = show all zeros

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
req_a  input  1  requester A wants a display update
value_a  input  IN_WIDTH  requester A binary value; held stable while req_a high
gnt_a  output  1  one-cycle pulse: value_a captured
req_b  input  1  requester B wants a display update
value_b  input  IN_WIDTH  requester B binary value; held stable while req_b high
gnt_b  output  1  one-cycle pulse: value_b captured
busy  output  1  conversion in progress
done  output  1  one-cycle pulse: new outputs valid
overflow  output  1  last value did not fit in NUM_DIGITS digits
bcd  output  4*NUM_DIGITS  converted BCD; digit 0 (ones) in bits 3:0
seg  output  7*NUM_DIGITS  active-low gfedcba patterns; digit 0 in bits 6:0

Behaviour:
- One clock; reset is asynchronous and active-low.
  - Ports are clk and resetn.
  - All state and outputs are registered.
- Reset values:
  - state IDLE; arbiter pointer favours A.
  - gnt_a, gnt_b, busy, done, overflow = 0; bcd = 0.
  - seg digit 0 = 1000000.
  - Digits 1..N-1 = 1111111 if BLANK_LEADING, else 1000000.
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE:
  - On a rising edge with req_a or req_b high, capture the winner's value and clear the BCD accumulator.
  - Advance to SHIFT with shift count 0.
  - The winner's gnt is high for exactly the following cycle; busy goes high the same cycle.
- Arbitration:
  - Only one requester asserting: it wins.
  - Both asserting: the one not granted most recently wins.
  - Pointer updates on every grant.
- Handshake:
  - Requesters hold req and value until they see gnt, then may drop or change them.
  - req still high after gnt is a new request.
  - Requests are sampled only in IDLE.
- SHIFT, each cycle:
  - Add 3 to every BCD digit >= 5.
  - Shift {bcd, value} left by 1.
  - If the bit shifted out of the top digit is 1, set the internal overflow flag (sticky for this conversion).
  - After IN_WIDTH shifts, go to UPDATE.
- UPDATE (1 cycle):
  - Register bcd, overflow and seg.
  - Pulse done for one cycle; drop busy; return to IDLE.
- Latency:
  - Capture edge = edge 0. done and new outputs are visible after edge IN_WIDTH+1.
  - Next capture at edge IN_WIDTH+2 at the earliest.
  - IN_WIDTH=8 gives 10 cycles per update.
- Segment encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Blanking: with BLANK_LEADING=1, digit i>0 shows 1111111 when it and all higher digits are 0. Digit 0 is never blanked.
- Overflow:
  - overflow=1; every seg digit = 0111111 (dash).
  - bcd holds the truncated low digits.
  - overflow clears on the next non-overflowing update.
- Outputs hold their values between updates.
- resetn asserted mid-SHIFT or mid-UPDATE aborts the conversion: no done, all outputs return to reset values.

Test Plan:
1. Reset: assert resetn=0 then release -> seg={1111111,1111111,1000000}, bcd=0, busy/done/overflow/gnt all 0.
2. req_a, value_a=255 -> gnt_a high one cycle after the capture edge; done after edge 9; bcd=12'h255; seg={0100100,0010010,0010010}.
3. value_a=7 -> seg={1111111,1111111,1111000}.
   - value_a=100 -> seg={1111001,1000000,1000000}.
   - value_a=7 with BLANK_LEADING=0 -> digits 2,1 = 1000000.
4. From reset, req_a (12) and req_b (34) both high and held -> grant order A, B.
   - Re-raise both -> A granted.
   - Each done shows the granted requester's value (bcd 12'h012, then 12'h034).
   - No double grant; busy high throughout each conversion.
5. NUM_DIGITS=2 instance, value 200 -> overflow=1, seg={0111111,0111111}.
   - Next value 42 -> overflow=0, bcd=8'h42.
6. Assert resetn at the 4th SHIFT cycle -> no done pulse, outputs at reset values.
   - After release, a new request with 99 -> bcd=12'h099 with correct timing.

Source files
------------

// File: rtl/seven_seg_display_controller.sv
// Shared seven-segment display controller: round-robin arbitration between two
// requesters, serial double-dabble binary-to-BCD conversion, and registered segment drive.
module seven_seg_display_controller #(
  parameter int IN_WIDTH      = 8,
  parameter int NUM_DIGITS    = 3,
  parameter int BLANK_LEADING = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_a,
  input  logic [IN_WIDTH-1:0]       value_a,
  output logic                      gnt_a,
  input  logic                      req_b,
  input  logic [IN_WIDTH-1:0]       value_b,
  output logic                      gnt_b,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [4*NUM_DIGITS-1:0]   bcd,
  output logic [7*NUM_DIGITS-1:0]   seg
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;
  localparam int CW = $clog2(IN_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] shift_val;
  logic [BW-1:0]       acc;
  logic [BW-1:0]       acc_adj;
  logic [CW-1:0]       cnt;
  logic                ovf_acc;
  logic                ptr;
  logic                pick_b;
  logic [SW-1:0]       seg_next;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Walk from the top digit down so a digit blanks only while everything above it is zero.
  function automatic logic [SW-1:0] encode_all(input logic [BW-1:0] b, input logic ovf);
    logic [SW-1:0] r;
    logic          nz;
    r  = '1;
    nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (b[4*i +: 4] != 4'd0) nz = 1'b1;
      if (ovf)
        r[7*i +: 7] = 7'b0111111;
      else if (BLANK_LEADING != 0 && i > 0 && !nz)
        r[7*i +: 7] = 7'b1111111;
      else
        r[7*i +: 7] = digit_seg(b[4*i +: 4]);
    end
    return r;
  endfunction

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // ptr=0 gives A priority on a tie, ptr=1 gives B priority.
  assign pick_b   = req_b && (!req_a || ptr);
  assign seg_next = encode_all(acc, ovf_acc);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      shift_val <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
      ptr       <= 1'b0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      bcd       <= '0;
      seg       <= encode_all('0, 1'b0);
    end else begin
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            shift_val <= pick_b ? value_b : value_a;
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            gnt_a     <= !pick_b;
            gnt_b     <= pick_b;
            ptr       <= !pick_b;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // The top bit of the adjusted accumulator is a carry into a digit we do not have.
          acc       <= {acc_adj[BW-2:0], shift_val[IN_WIDTH-1]};
          shift_val <= shift_val << 1;
          if (acc_adj[BW-1]) ovf_acc <= 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(IN_WIDTH - 1)) state <= UPDATE;
        end
        UPDATE: begin
          bcd      <= acc;
          overflow <= ovf_acc;
          seg      <= seg_next;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_display_controller.sv
// Scoreboard bench for seven_seg_display_controller: three configurations, directed
// vectors with hand-computed BCD/segment results, monitors pop expectations on done.
module tb_seven_seg_display_controller;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000,
                         BL = 7'b1111111, DS = 7'b0111111;

  typedef struct {
    logic [11:0] bcd;
    logic [20:0] seg;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // main instance: defaults (3 digits, blanking)
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [7:0]  value_a = '0, value_b = '0;
  logic        gnt_a, gnt_b, busy, done, overflow;
  logic [11:0] bcd;
  logic [20:0] seg;

  // no-blanking instance
  logic        nb_req_a = 1'b0;
  logic [7:0]  nb_value_a = '0;
  logic        nb_gnt_a, nb_gnt_b, nb_busy, nb_done, nb_overflow;
  logic [11:0] nb_bcd;
  logic [20:0] nb_seg;

  // two-digit instance
  logic        two_req_a = 1'b0;
  logic [7:0]  two_value_a = '0;
  logic        two_gnt_a, two_gnt_b, two_busy, two_done, two_overflow;
  logic [7:0]  two_bcd;
  logic [13:0] two_seg;

  seven_seg_display_controller dut (
    .clk(clk), .resetn(resetn),
    .req_a(req_a), .value_a(value_a), .gnt_a(gnt_a),
    .req_b(req_b), .value_b(value_b), .gnt_b(gnt_b),
    .busy(busy), .done(done), .overflow(overflow), .bcd(bcd), .seg(seg)
  );

  seven_seg_display_controller #(.IN_WIDTH(8), .NUM_DIGITS(3), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .resetn(resetn),
    .req_a(nb_req_a), .value_a(nb_value_a), .gnt_a(nb_gnt_a),
    .req_b(1'b0), .value_b(8'd0), .gnt_b(nb_gnt_b),
    .busy(nb_busy), .done(nb_done), .overflow(nb_overflow), .bcd(nb_bcd), .seg(nb_seg)
  );

  seven_seg_display_controller #(.IN_WIDTH(8), .NUM_DIGITS(2), .BLANK_LEADING(1)) dut_two (
    .clk(clk), .resetn(resetn),
    .req_a(two_req_a), .value_a(two_value_a), .gnt_a(two_gnt_a),
    .req_b(1'b0), .value_b(8'd0), .gnt_b(two_gnt_b),
    .busy(two_busy), .done(two_done), .overflow(two_overflow), .bcd(two_bcd), .seg(two_seg)
  );

  int   checks = 0;
  int   errors = 0;
  int   sel = 0;
  exp_t q_main[$], q_nb[$], q_two[$];
  exp_t em, enb, etwo;
  logic sel_gnt_a, sel_gnt_b, sel_done, sel_busy;

  always_comb begin
    sel_gnt_a = gnt_a;
    sel_gnt_b = gnt_b;
    sel_done  = done;
    sel_busy  = busy;
    if (sel == 1) begin
      sel_gnt_a = nb_gnt_a; sel_gnt_b = nb_gnt_b; sel_done = nb_done; sel_busy = nb_busy;
    end else if (sel == 2) begin
      sel_gnt_a = two_gnt_a; sel_gnt_b = two_gnt_b; sel_done = two_done; sel_busy = two_busy;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitors: one per instance, pop on each done pulse.
  always @(negedge clk) begin
    if (done) begin
      if (q_main.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL main unexpected done: got done=1, expected no update pending");
      end else begin
        em = q_main.pop_front();
        checkOutput("main bcd", bcd, em.bcd);
        checkOutput("main seg", seg, em.seg);
        checkOutput("main overflow", overflow, em.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (nb_done) begin
      if (q_nb.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL nb unexpected done: got done=1, expected no update pending");
      end else begin
        enb = q_nb.pop_front();
        checkOutput("nb bcd", nb_bcd, enb.bcd);
        checkOutput("nb seg", nb_seg, enb.seg);
        checkOutput("nb overflow", nb_overflow, enb.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (two_done) begin
      if (q_two.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL two unexpected done: got done=1, expected no update pending");
      end else begin
        etwo = q_two.pop_front();
        checkOutput("two bcd", two_bcd, etwo.bcd);
        checkOutput("two seg", two_seg, etwo.seg);
        checkOutput("two overflow", two_overflow, etwo.ovf);
      end
    end
  end

  task automatic pushExpected(input int s, input logic [11:0] eb, input logic [20:0] es, input logic eo);
    exp_t e;
    e.bcd = eb; e.seg = es; e.ovf = eo;
    if (s == 0) q_main.push_back(e);
    else if (s == 1) q_nb.push_back(e);
    else q_two.push_back(e);
  endtask

  task automatic waitGrant(input bit exp_b, input int exp_n, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel_gnt_a || sel_gnt_b) && n < 40);
    checkOutput({tag, " grant latency"}, n, exp_n);
    checkOutput({tag, " gnt_a"}, sel_gnt_a, !exp_b);
    checkOutput({tag, " gnt_b"}, sel_gnt_b, exp_b);
    checkOutput({tag, " busy at grant"}, sel_busy, 1);
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    int busy_low = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) checkOutput({tag, " gnt single pulse"}, sel_gnt_a | sel_gnt_b, 0);
      if (!sel_done && !sel_busy) busy_low++;
    end while (!sel_done && n < 40);
    checkOutput({tag, " done latency"}, n, 9);
    checkOutput({tag, " busy held during conversion"}, busy_low, 0);
    checkOutput({tag, " busy dropped at done"}, sel_busy, 0);
  endtask

  task automatic applyStimulus(input int s, input bit use_b, input logic [7:0] val,
                               input logic [11:0] eb, input logic [20:0] es, input logic eo);
    sel = s;
    pushExpected(s, eb, es, eo);
    if (s == 1) begin nb_value_a = val; nb_req_a = 1'b1; end
    else if (s == 2) begin two_value_a = val; two_req_a = 1'b1; end
    else if (use_b) begin value_b = val; req_b = 1'b1; end
    else begin value_a = val; req_a = 1'b1; end
    waitGrant(use_b, 1, $sformatf("req %0d", val));
    req_a = 1'b0; req_b = 1'b0; nb_req_a = 1'b0; two_req_a = 1'b0;
    value_a = 8'hxx; value_b = 8'hxx;
    waitDone($sformatf("val %0d", val));
  endtask

  task automatic pulseReset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dones;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("reset seg", seg, {BL, BL, S0});
    checkOutput("reset bcd", bcd, 0);
    checkOutput("reset flags", {gnt_a, gnt_b, busy, done, overflow}, 0);
    checkOutput("reset nb seg", nb_seg, {S0, S0, S0});
    checkOutput("reset two seg", two_seg, {BL, S0});

    $display("[TB] single-requester conversions");
    applyStimulus(0, 0, 8'd255, 12'h255, {S2, S5, S5}, 1'b0);
    applyStimulus(0, 0, 8'd7,   12'h007, {BL, BL, S7}, 1'b0);
    applyStimulus(0, 1, 8'd100, 12'h100, {S1, S0, S0}, 1'b0);
    applyStimulus(0, 0, 8'd0,   12'h000, {BL, BL, S0}, 1'b0);
    applyStimulus(0, 1, 8'd10,  12'h010, {BL, S1, S0}, 1'b0);

    $display("[TB] round-robin arbitration");
    pulseReset();
    sel = 0;
    value_a = 8'd12; value_b = 8'd34;
    for (int round = 0; round < 2; round++) begin
      pushExpected(0, 12'h012, {BL, S1, S2}, 1'b0);
      pushExpected(0, 12'h034, {BL, S3, S4}, 1'b0);
      req_a = 1'b1; req_b = 1'b1;
      waitGrant(1'b0, 1, $sformatf("rr%0d A", round));
      req_a = 1'b0;
      waitDone($sformatf("rr%0d A", round));
      waitGrant(1'b1, 1, $sformatf("rr%0d B", round));
      req_b = 1'b0;
      waitDone($sformatf("rr%0d B", round));
    end

    $display("[TB] reset during conversion");
    value_a = 8'd150; req_a = 1'b1;
    waitGrant(1'b0, 1, "abort");
    req_a = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("abort bcd", bcd, 0);
    checkOutput("abort seg", seg, {BL, BL, S0});
    checkOutput("abort flags", {gnt_a, gnt_b, busy, done, overflow}, 0);
    @(negedge clk);
    resetn = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("no done after abort", dones, 0);
    applyStimulus(0, 0, 8'd99, 12'h099, {BL, S9, S9}, 1'b0);

    $display("[TB] no-blanking instance");
    applyStimulus(1, 0, 8'd7,  12'h007, {S0, S0, S7}, 1'b0);
    applyStimulus(1, 0, 8'd40, 12'h040, {S0, S4, S0}, 1'b0);

    $display("[TB] two-digit overflow instance");
    applyStimulus(2, 0, 8'd200, 12'h000, {7'd0, DS, DS}, 1'b1);
    applyStimulus(2, 0, 8'd42,  12'h042, {7'd0, S4, S2}, 1'b0);
    applyStimulus(2, 0, 8'd100, 12'h000, {7'd0, DS, DS}, 1'b1);
    applyStimulus(2, 0, 8'd99,  12'h099, {7'd0, S9, S9}, 1'b0);

    @(negedge clk);
    checkOutput("main queue drained", q_main.size(), 0);
    checkOutput("nb queue drained", q_nb.size(), 0);
    checkOutput("two queue drained", q_two.size(), 0);
    checkOutput("unused gnt_b stays low", {nb_gnt_b, two_gnt_b}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
